fact_mmio_responder: RTL and testbench
======================================

Name: fact_mmio_responder

Overview:
- Memory-mapped factorial accelerator.
- Acts as the responder on the processor's data-memory bus: it answers the datapath's store/load traffic (we, address, write data, read data) for one decoded address window.
- Software writes n, writes GO, polls STATUS, then reads RESULT.
- The system address decoder supplies a select; this block sees only word-offset bits.

Parameters:
- N_W, 4: width of the n operand register.
- MAX_N, 12: largest n whose factorial fits in 32 bits; n > MAX_N is an error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- we  input  1  store strobe, already qualified by the address-decoder select.
- addr  input  2  word offset, bus address bits [3:2].
- wd  input  32  store data from the datapath.
- rd  output  32  load data; combinational from addr and internal registers.
- irq_done  output  1  level copy of STATUS.done.

Behaviour:
- Register map (word offsets):
  - 0 N: R/W, wd[N_W-1:0]; reads zero-extended.
  - 1 GO: write wd[0]=1 requests a start; reads {31'b0, busy}.
  - 2 STATUS: RO, {30'b0, err, done}.
  - 3 RESULT: RO, 32 bits.
  - Writes to offsets 2 and 3 are ignored.
- Reset (rst=0, asynchronous):
  - state=IDLE; N, cnt, prod, RESULT = 0; done = err = 0.
  - Therefore rd=0 for every offset and irq_done=0.
  - Reset mid-computation aborts with no residue.
- States: IDLE, BUSY, DONE. busy=1 only in BUSY.
- Start (GO write with wd[0]=1, accepted in IDLE or DONE), at the write edge:
  - done <= 0, err <= 0.
  - If N > MAX_N: RESULT <= 0, err <= 1, done <= 1, state <= DONE.
  - Otherwise: cnt <= N, prod <= 1, state <= BUSY.
- BUSY, each edge:
  - If cnt <= 1: RESULT <= prod, done <= 1, state <= DONE.
  - Otherwise: prod <= prod*cnt (low 32 bits; no overflow for n <= MAX_N), cnt <= cnt-1.
- Latency: done reads 1 exactly max(N,1) edges after the GO edge. Error case: 1 edge.
- GO write with wd[0]=0, or any GO write while BUSY: ignored (no restart, no state change).
- N write while BUSY: N updates immediately; the running computation uses the captured cnt. The new N is used by the next GO.
- Simultaneous N write and GO write cannot occur (single write port, one offset per cycle).
- RESULT holds the last completed value until the next completion. During BUSY it returns the previous result.
- DONE persists (done=1) until the next accepted GO or reset. DONE→BUSY restart is allowed without passing through IDLE.
- rd is purely combinational from addr; loads have no side effects.

Test Plan:
- Reset: assert rst=0 mid-BUSY (N=10) → rd=0 at all four offsets, irq_done=0; after release, state is IDLE and a GO on N=3 completes normally.
- N=5 flow: write N=5, write GO=1 → STATUS=0 and GO reads 1 for 4 edges; on the 5th edge STATUS=1 and RESULT=120 (0x78).
- Boundaries:
  - N=0 → done after 1 edge, RESULT=1.
  - N=1 → done after 1 edge, RESULT=1.
  - N=12 → done after 12 edges, RESULT=479001600 (0x1C8CFC00).
- Error: N=13, GO → next edge STATUS=3 (err=1, done=1) and RESULT=0; then N=4, GO → err clears, after 4 edges RESULT=24.
- Ignored writes while BUSY:
  - GO with N=6 running: second GO ignored, final RESULT=720, latency unchanged (6 edges).
  - Write N=2 mid-run: RESULT still 720; N reads 2.
  - Writes to offsets 2 and 3: no effect.
- Restart from DONE: after RESULT=120, GO with N=3 → during BUSY RESULT still reads 120 and done=0; after 3 edges RESULT=6 and irq_done=1.

Source files
------------

// File: rtl/fact_mmio_responder.sv
// Memory-mapped factorial accelerator. It answers bus stores and loads
// for one decoded window of four 32-bit registers:
//   offset 0 = N, 1 = GO/busy, 2 = STATUS {err, done}, 3 = RESULT.
// Software writes n, writes GO, polls STATUS, then reads RESULT.
module fact_mmio_responder #(
  parameter int N_W   = 4,
  parameter int MAX_N = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]     ADDR_N      = 2'd0;
  localparam logic [1:0]     ADDR_GO     = 2'd1;
  localparam logic [1:0]     ADDR_STATUS = 2'd2;
  localparam logic [1:0]     ADDR_RESULT = 2'd3;
  localparam logic [N_W-1:0] MAX_N_L     = N_W'(MAX_N);
  localparam logic [N_W-1:0] ONE_N       = N_W'(1);

  state_t         state_q, state_d;
  logic [N_W-1:0] n_q, n_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic [31:0]    prod_q, prod_d;
  logic [31:0]    result_q, result_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           goReq;
  logic           busy;
  logic [31:0]    cntExt;

  assign goReq    = we && (addr == ADDR_GO) && wd[0];
  assign busy     = (state_q == BUSY);
  assign cntExt   = {{(32-N_W){1'b0}}, cnt_q};
  assign irq_done = done_q;

  // Register state; an asynchronous reset abandons any running computation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next state: N is always writable; GO only starts when not busy; BUSY multiplies down.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;

    if (we && (addr == ADDR_N)) begin
      n_d = wd[N_W-1:0];
    end

    case (state_q)
      IDLE, DONE: begin
        if (goReq) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (n_q > MAX_N_L) begin
            result_d = '0;
            err_d    = 1'b1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d   = n_q;
            prod_d  = 32'd1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q <= ONE_N) begin
          result_d = prod_q;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          prod_d = prod_q * cntExt;
          cnt_d  = cnt_q - ONE_N;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load data is a pure mux of the addressed register; reads have no side effects.
  always_comb begin
    rd = '0;
    case (addr)
      ADDR_N:      rd = {{(32-N_W){1'b0}}, n_q};
      ADDR_GO:     rd = {31'b0, busy};
      ADDR_STATUS: rd = {30'b0, err_q, done_q};
      ADDR_RESULT: rd = result_q;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_mmio_responder.sv
// Directed bench for fact_mmio_responder: a table of n values with
// hand-computed factorials and latencies, plus hand-written sequences
// for reset, busy-time writes and restart from DONE.
module tb_fact_mmio_responder;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq_done;

  int total;
  int bad;

  typedef struct {
    logic [31:0] nVal;
    logic [31:0] expResult;
    int          expLatency;
    logic        expErr;
  } vec_t;

  vec_t vecs[7];

  fact_mmio_responder #(.N_W(4), .MAX_N(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .irq_done (irq_done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus store; returns 1 ns after the edge that performs it.
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we   = 1'b1;
    addr = a;
    wd   = d;
    @(posedge clk);
    #1;
    we   = 1'b0;
    wd   = '0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after a GO edge; returns edges taken, or -1 on timeout.
  task automatic waitDone(output int edges);
    logic [31:0] st;
    edges = -1;
    for (int e = 1; e <= 20; e++) begin
      nextEdge();
      readReg(2'd2, st);
      if (st[0]) begin
        edges = e;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    int          lat;

    total = 0;
    bad   = 0;
    we    = 1'b0;
    addr  = 2'd0;
    wd    = '0;
    rst   = 1'b0;

    vecs[0] = '{32'd0,  32'd1,         1,  1'b0};
    vecs[1] = '{32'd1,  32'd1,         1,  1'b0};
    vecs[2] = '{32'd12, 32'd479001600, 12, 1'b0};
    vecs[3] = '{32'd13, 32'd0,         1,  1'b1};
    vecs[4] = '{32'd4,  32'd24,        4,  1'b0};
    vecs[5] = '{32'd15, 32'd0,         1,  1'b1};
    vecs[6] = '{32'd7,  32'd5040,      7,  1'b0};

    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      readReg(2'(a), v);
      checkOutput($sformatf("reset_rd%0d", a), v, 32'd0);
    end
    checkOutput("reset_irq", {31'b0, irq_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // N=5 flow, cycle by cycle.
    applyStimulus(2'd0, 32'd5);
    readReg(2'd0, v);
    checkOutput("n_readback", v, 32'd5);
    applyStimulus(2'd1, 32'd1);
    for (int e = 1; e <= 4; e++) begin
      nextEdge();
      readReg(2'd2, v);
      checkOutput($sformatf("n5_status_e%0d", e), v, 32'd0);
      readReg(2'd1, v);
      checkOutput($sformatf("n5_busy_e%0d", e), v, 32'd1);
    end
    nextEdge();
    readReg(2'd2, v);
    checkOutput("n5_status_done", v, 32'd1);
    readReg(2'd3, v);
    checkOutput("n5_result", v, 32'd120);
    readReg(2'd1, v);
    checkOutput("n5_busy_clear", v, 32'd0);

    // Restart from DONE: old result visible while busy.
    applyStimulus(2'd0, 32'd3);
    applyStimulus(2'd1, 32'd1);
    for (int e = 1; e <= 2; e++) begin
      nextEdge();
      readReg(2'd3, v);
      checkOutput($sformatf("restart_oldres_e%0d", e), v, 32'd120);
      checkOutput($sformatf("restart_irq_e%0d", e), {31'b0, irq_done}, 32'd0);
    end
    nextEdge();
    readReg(2'd3, v);
    checkOutput("restart_result", v, 32'd6);
    checkOutput("restart_irq", {31'b0, irq_done}, 32'd1);

    // Table of n values: latency, result and status.
    foreach (vecs[i]) begin
      applyStimulus(2'd0, vecs[i].nVal);
      applyStimulus(2'd1, 32'd1);
      waitDone(lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLatency));
      readReg(2'd3, v);
      checkOutput($sformatf("vec%0d_result", i), v, vecs[i].expResult);
      readReg(2'd2, v);
      checkOutput($sformatf("vec%0d_status", i), v, {30'b0, vecs[i].expErr, 1'b1});
    end

    // Busy-time writes: second GO, N rewrite and STATUS write must not disturb the run.
    applyStimulus(2'd0, 32'd6);
    applyStimulus(2'd1, 32'd1);
    nextEdge();
    nextEdge();
    applyStimulus(2'd1, 32'd1);
    applyStimulus(2'd0, 32'd2);
    applyStimulus(2'd2, 32'hFFFF_FFFF);
    readReg(2'd2, v);
    checkOutput("busy_status_e5", v, 32'd0);
    nextEdge();
    readReg(2'd2, v);
    checkOutput("busy_status_e6", v, 32'd1);
    readReg(2'd3, v);
    checkOutput("busy_result", v, 32'd720);
    readReg(2'd0, v);
    checkOutput("busy_n_updated", v, 32'd2);
    applyStimulus(2'd3, 32'h0000_1234);
    applyStimulus(2'd2, 32'h0000_0000);
    applyStimulus(2'd1, 32'd2);
    nextEdge();
    readReg(2'd3, v);
    checkOutput("ignored_wr_result", v, 32'd720);
    readReg(2'd2, v);
    checkOutput("ignored_wr_status", v, 32'd1);
    readReg(2'd1, v);
    checkOutput("ignored_go0_busy", v, 32'd0);

    // Reset in the middle of a long computation, then a clean run.
    applyStimulus(2'd0, 32'd10);
    applyStimulus(2'd1, 32'd1);
    nextEdge();
    nextEdge();
    #2;
    rst = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) begin
      readReg(2'(a), v);
      checkOutput($sformatf("midreset_rd%0d", a), v, 32'd0);
    end
    checkOutput("midreset_irq", {31'b0, irq_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2'd0, 32'd3);
    applyStimulus(2'd1, 32'd1);
    waitDone(lat);
    checkOutput("postreset_latency", 32'(lat), 32'd3);
    readReg(2'd3, v);
    checkOutput("postreset_result", v, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
